// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit: instruction-fetch stage, writer side of the IF/ID register.
// Owns the PC, issues requests to a variable-latency instruction memory,
// presents one instruction (or a NOP bubble) to IF/ID every cycle, honours
// the shared hold line and applies branch/jump redirects.
//
// Configuration macro: FETCH_PERF_CNT_EN enables the stall/flush counters;
// when undefined both counter ports are tied to zero.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   hold                  hazard stall shared with IF/ID (1 = no capture)
//   redirect_valid/_pc    one-cycle taken branch/jump and its target
//   imem_req/_addr        memory request and address
//   imem_ack/_rdata       memory read-data valid and instruction word
//   PCplus4               presented instruction address + PC_STEP
//   instrOut              presented instruction, 0 when none
//   instr_valid           instrOut carries a real instruction
//   IF_flush              squash indication towards IF/ID
//   stall_cnt, flush_cnt  performance counters
// ---------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hold,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PCplus4,
   output logic [31:0] instrOut,
   output logic        instr_valid,
   output logic        IF_flush,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_FULL  = 2'd1,
      S_DROP  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] ibuf_q, ibuf_d;
   logic [XLEN-1:0] ibuf_pc_q, ibuf_pc_d;
   // Address of an abandoned request; the memory needs it stable until ack.
   logic [XLEN-1:0] drop_addr_q, drop_addr_d;

   logic            fetch_hit;
   logic            have_instr;
   logic [XLEN-1:0] pres_word;
   logic [XLEN-1:0] pres_pc;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         ibuf_q      <= '0;
         ibuf_pc_q   <= RESET_PC;
         drop_addr_q <= RESET_PC;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ibuf_q      <= ibuf_d;
         ibuf_pc_q   <= ibuf_pc_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   // Next-state logic; redirect outranks hold and consumption
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ibuf_d      = ibuf_q;
      ibuf_pc_d   = ibuf_pc_q;
      drop_addr_d = drop_addr_q;
      case (state_q)
         S_FETCH: begin
            if (redirect_valid) begin
               pc_d        = redirect_pc;
               drop_addr_d = pc_q;
               if (!imem_ack) state_d = S_DROP;
            end else if (imem_ack) begin
               if (hold) begin
                  ibuf_d    = imem_rdata;
                  ibuf_pc_d = pc_q;
                  state_d   = S_FULL;
               end else begin
                  pc_d = pc_q + STEP;
               end
            end
         end
         S_FULL: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               ibuf_d  = '0;
               state_d = S_FETCH;
            end else if (!hold) begin
               pc_d    = ibuf_pc_q + STEP;
               state_d = S_FETCH;
            end
         end
         S_DROP: begin
            if (redirect_valid) pc_d = redirect_pc;
            if (imem_ack)       state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Memory request; gated by rst_n so it is low while reset is asserted
   always_comb begin
      imem_req  = rst_n && (state_q != S_FULL);
      imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
   end

   // Presented instruction towards IF/ID
   always_comb begin
      fetch_hit  = (state_q == S_FETCH) && imem_ack;
      have_instr = fetch_hit || (state_q == S_FULL);
      pres_word  = '0;
      pres_pc    = pc_q;
      if (fetch_hit) begin
         pres_word = imem_rdata;
         pres_pc   = pc_q;
      end else if (state_q == S_FULL) begin
         pres_word = ibuf_q;
         pres_pc   = ibuf_pc_q;
      end
      instr_valid = have_instr && !redirect_valid;
      instrOut    = instr_valid ? pres_word : '0;
      PCplus4     = pres_pc + STEP;
      IF_flush    = rst_n && redirect_valid;
   end

`ifdef FETCH_PERF_CNT_EN
   logic [XLEN-1:0] stall_cnt_q;
   logic [XLEN-1:0] flush_cnt_q;

   // Stall cycles: request outstanding without data; flush cycles: redirects
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (imem_req && !imem_ack) stall_cnt_q <= stall_cnt_q + XLEN'(1);
         if (redirect_valid)        flush_cnt_q <= flush_cnt_q + XLEN'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit: directed bench for if_fetch_unit with a small
// wait-state memory model. Inputs change on the falling edge and outputs
// are sampled 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        hold;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] PCplus4;
   logic [31:0] instrOut;
   logic        instr_valid;
   logic        IF_flush;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   // Memory model controls
   int unsigned waits;
   int unsigned wcnt;
   logic        ov_en;
   logic [31:0] ov_addr;
   logic [31:0] ov_data;

   int n_checks;
   int n_errors;

   if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .hold           (hold),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .PCplus4        (PCplus4),
      .instrOut       (instrOut),
      .instr_valid    (instr_valid),
      .IF_flush       (IF_flush),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: ack after 'waits' idle request cycles; word = address unless overridden
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    wcnt <= 0;
      else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
      else                           wcnt <= 0;
   end
   assign imem_ack   = imem_req && (wcnt == waits);
   assign imem_rdata = (ov_en && imem_addr == ov_addr) ? ov_data : imem_addr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_errors = 0;
      rst_n = 1'b0; hold = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
      waits = 0; ov_en = 1'b0; ov_addr = 32'h10; ov_data = 32'h0000_AAAA;

      // Reset values, even with a redirect pulse on the input
      #2;
      check("rst_req",    32'(imem_req),    32'd0);
      check("rst_instr",  instrOut,         32'd0);
      check("rst_valid",  32'(instr_valid), 32'd0);
      check("rst_flush",  32'(IF_flush),    32'd0);
      check("rst_pcp4",   PCplus4,          32'd4);
      check("rst_stall",  stall_cnt,        32'd0);
      redirect_valid = 1'b0;
      repeat (2) @(posedge clk);

      // 1: zero-wait memory, one instruction per cycle
      @(negedge clk); rst_n = 1'b1; #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         check("t1_instr", instrOut,         32'(4 * i));
         check("t1_pcp4",  PCplus4,          32'(4 * i + 4));
         check("t1_valid", 32'(instr_valid), 32'd1);
      end

      // 2: ack of 0xAAAA at 0x10 while hold=1 for 3 cycles
      ov_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); hold = (k < 3); #1;
         check("t2_instr", instrOut,         32'h0000_AAAA);
         check("t2_pcp4",  PCplus4,          32'h14);
         check("t2_valid", 32'(instr_valid), 32'd1);
         if (k > 0) check("t2_req", 32'(imem_req), 32'd0);
      end

      // 3: two wait states per instruction, starting at 0x14
      for (int n = 0; n < 2; n++) begin
         for (int w = 0; w < 3; w++) begin
            @(negedge clk); hold = 1'b0; waits = 2; #1;
            if (n == 0 && w == 0) check("t2_next_addr", imem_addr, 32'h14);
            if (w < 2) begin
               check("t3_bubble_instr", instrOut,         32'd0);
               check("t3_bubble_valid", 32'(instr_valid), 32'd0);
            end else begin
               check("t3_instr", instrOut,  32'(32'h14 + 4 * n));
               check("t3_stall", stall_cnt, PERF ? 32'(2 * n + 2) : 32'd0);
            end
         end
      end

      // 4: redirect to 0x100 while the request at 0x20 is outstanding
      @(negedge clk); waits = 0; #1;
      check("t4_pre_instr", instrOut, 32'h1C);
      @(negedge clk); waits = 1; redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
      check("t4_addr_a",  imem_addr,        32'h20);
      check("t4_flush_a", 32'(IF_flush),    32'd1);
      check("t4_valid_a", 32'(instr_valid), 32'd0);
      check("t4_instr_a", instrOut,         32'd0);
      @(negedge clk); redirect_valid = 1'b0; #1;
      check("t4_ack_b",   32'(imem_ack),    32'd1);
      check("t4_addr_b",  imem_addr,        32'h20);
      check("t4_flush_b", 32'(IF_flush),    32'd0);
      check("t4_valid_b", 32'(instr_valid), 32'd0);
      @(negedge clk); waits = 0; #1;
      check("t4_addr_c",  imem_addr,        32'h100);
      check("t4_instr_c", instrOut,         32'h100);
      check("t4_fcnt",    flush_cnt,        PERF ? 32'd1 : 32'd0);
      check("t4_scnt",    stall_cnt,        PERF ? 32'd5 : 32'd0);

      // 5: redirect while FULL under hold
      hold = 1'b1;
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
      check("t5_req",   32'(imem_req),    32'd0);
      check("t5_instr", instrOut,         32'd0);
      check("t5_valid", 32'(instr_valid), 32'd0);
      check("t5_flush", 32'(IF_flush),    32'd1);
      @(negedge clk); redirect_valid = 1'b0; hold = 1'b0; #1;
      check("t5_addr",  imem_addr, 32'h200);
      check("t5_next",  instrOut,  32'h200);
      check("t5_pcp4",  PCplus4,   32'h204);
      check("t5_fcnt",  flush_cnt, PERF ? 32'd2 : 32'd0);

      // PC wrap and pass-through of low redirect bits
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
      @(negedge clk); redirect_valid = 1'b0; #1;
      check("wrap_instr", instrOut, 32'hFFFF_FFFC);
      check("wrap_pcp4",  PCplus4,  32'h0);
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
      check("wrap_addr",  imem_addr, 32'h0);
      @(negedge clk); redirect_valid = 1'b0; #1;
      check("lowbits_addr", imem_addr, 32'h103);

      // 6: reset pulsed mid-request at 0x40
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
      @(negedge clk); redirect_valid = 1'b0; waits = 3; #1;
      check("t6_addr", imem_addr, 32'h40);
      check("t6_wait", 32'(instr_valid), 32'd0);
      #1 rst_n = 1'b0; #1;
      check("t6_rst_req",   32'(imem_req),    32'd0);
      check("t6_rst_instr", instrOut,         32'd0);
      check("t6_rst_valid", 32'(instr_valid), 32'd0);
      check("t6_rst_pcp4",  PCplus4,          32'd4);
      check("t6_rst_addr",  imem_addr,        32'd0);
      check("t6_rst_fcnt",  flush_cnt,        32'd0);
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1; waits = 0; #1;
      check("t6_addr_after", imem_addr,        32'd0);
      check("t6_req_after",  32'(imem_req),    32'd1);
      check("t6_instr_after", instrOut,        32'd0);
      check("t6_valid_after", 32'(instr_valid), 32'd1);
      @(negedge clk); #1;
      check("t6_second", instrOut, 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage. It is the writer side of the IF/ID pipeline register.
- Owns the PC and issues requests to a variable-latency instruction memory.
- Presents PCplus4/instrOut to IF/ID every cycle, honouring the shared hold line.
- Applies branch/jump redirects and generates IF_flush.
- IF/ID latches whenever hold=0. Squashing is therefore done here, by presenting a NOP (32'h0); IF_flush is also driven for IF/ID.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset.
PC_STEP, 4, byte increment per sequential instruction.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
hold  in  1  hazard stall; same signal IF/ID sees; 1 = IF/ID does not capture this edge
redirect_valid  in  1  one-cycle pulse: branch/jump taken
redirect_pc  in  32  target PC, valid with redirect_valid
imem_req  out  1  instruction memory request
imem_addr  out  32  request address, stable while imem_req=1 and no ack
imem_ack  in  1  read data valid this cycle; only asserted while imem_req=1
imem_rdata  in  32  instruction word
PCplus4  out  32  address of presented instruction + PC_STEP (to IF/ID PCplus4)
instrOut  out  32  presented instruction, 0 when none (to IF/ID instrIn)
instr_valid  out  1  instrOut is a real instruction
IF_flush  out  1  equals redirect_valid (to IF/ID IF_flush)
stall_cnt  out  32  see Optional Feature
flush_cnt  out  32  see Optional Feature

Behaviour:
- Registers: pc (address being fetched), state, ibuf[31:0], ibuf_pc.
- States:
  - FETCH: request outstanding at pc.
  - FULL: word held in ibuf, awaiting consumption.
  - DROP: outstanding request must be discarded.
- Reset (async, rst_n=0):
  - state=FETCH, pc=RESET_PC, ibuf=0, counters=0.
  - Outputs during reset: imem_req=0, instrOut=0, instr_valid=0, IF_flush=0, PCplus4=RESET_PC+4.
  - imem_req rises in the first cycle after rst_n deasserts.
  - imem shares rst_n, so no stale ack survives a reset, including a reset mid-request.
- imem_req=1 in FETCH and DROP.
  - imem_addr=pc in FETCH.
  - In DROP, imem_addr holds the abandoned address until ack.
- Presented instruction (combinational):
  - FETCH & imem_ack: imem_rdata / pc.
  - FULL: ibuf / ibuf_pc.
  - Otherwise: 0, instr_valid=0, PCplus4=pc+4.
- Consumption: a valid presented instruction with hold=0 at an edge is taken by IF/ID.
- FETCH transitions:
  - ack & !hold: consume, pc<=pc+4, stay FETCH. Zero-wait memory gives 1 instr/cycle.
  - ack & hold: ibuf<=rdata, ibuf_pc<=pc, go FULL. pc is unchanged until consumed.
  - No ack: stay FETCH. A NOP is presented, so IF/ID latches a bubble if hold=0.
- FULL transitions:
  - hold=1: stay; the outputs are identical every cycle.
  - hold=0: consume, pc<=ibuf_pc+4, go FETCH.
- Redirect (redirect_valid=1) has priority over everything, including hold:
  - IF_flush=1, instrOut=0, instr_valid=0 that cycle. Nothing is consumed.
  - pc<=redirect_pc. ibuf is discarded.
  - FULL -> FETCH.
  - FETCH with ack -> FETCH (data dropped).
  - FETCH without ack -> DROP.
- DROP transitions:
  - On ack: discard the data, go FETCH at the updated pc.
  - A new redirect while in DROP only updates pc.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). The low 2 bits of redirect_pc are passed through unchanged.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - stall_cnt increments each cycle with imem_req=1 & imem_ack=0.
  - flush_cnt increments each cycle redirect_valid=1.
  - Both are 32-bit, wrap, and reset to 0.
- Undefined: both ports tied to 0, no counter flops.
- The port list is identical either way.

Test Plan:
1. Reset release, imem acks every cycle with word = addr, hold=0 -> instrOut 0,4,8,C on consecutive cycles; PCplus4 4,8,C,10; instr_valid=1 throughout.
2. Ack of word 0xAAAA at pc=0x10 while hold=1 for 3 cycles -> instrOut=0xAAAA and PCplus4=0x14 stable for 4 cycles; imem_req=0 in FULL; next request is at 0x14 after hold drops.
3. 2-wait-state memory, hold=0 -> instr_valid=0 and instrOut=0 for 2 cycles per instruction; stall_cnt=+2 per instruction when FETCH_PERF_CNT_EN is defined.
4. redirect_valid with redirect_pc=0x100 while a request at 0x20 is outstanding, ack 1 cycle later -> IF_flush=1 for 1 cycle; the 0x20 data is never presented; next imem_addr=0x100; flush_cnt=1.
5. redirect_valid while in FULL with hold=1 -> ibuf dropped, instrOut=0 that cycle; next fetch is at the target.
6. rst_n pulsed low mid-request at pc=0x40 -> outputs drop to reset values immediately; fetch restarts at RESET_PC.
